// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter, with level and sticky error status.
// Optional macro UART_TX_FIFO_STATS_EN adds tx_count/drop_count statistics outputs.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  udf,
  input  logic                  err_clr,
  output logic [7:0]            tx_byte,
  output logic                  tx_byte_dv,
  input  logic                  tx_byte_rd
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]           tx_count,
  output logic [7:0]            drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LVL    = (DEPTH_LOG2+1)'(AF_THRESH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  do_wr, do_pop, ovf_set, udf_set;

  assign empty       = (level_q == '0);
  assign full        = (level_q == DEPTH_LVL);
  assign almost_full = (level_q >= AF_LVL);
  assign level       = level_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

  // Handshake: tx_byte_dv high means tx_byte holds the head byte and stays
  // stable until the edge where tx_byte_rd is high; that edge consumes it.
  assign tx_byte_dv  = ~empty;
  assign tx_byte     = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the same cycle pops a byte.
  assign do_pop  = tx_byte_rd & ~empty & ~flush;
  assign do_wr   = wr_en & (~full | tx_byte_rd) & ~flush;
  assign ovf_set = wr_en & full & ~tx_byte_rd;
  assign udf_set = tx_byte_rd & empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // A fresh error outranks a same-cycle clear.
      if (err_clr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] tx_count_q;
  logic [7:0]  drop_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      if (do_pop) tx_count_q <= tx_count_q + 1'b1;
      if (ovf_set && !flush && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign tx_count   = tx_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule
